// File: rtl/fir_decim_out.sv
// fir_decim_out: output decimator and small elastic FIFO behind an FIR.
// A sample is kept when it arrives at phase 0 of a free-running (en-driven)
// phase counter. Kept samples are queued in a DEPTH-entry FIFO. The consumer
// drains the FIFO with a valid/ready handshake. A kept sample that finds the
// FIFO full is dropped, and the sticky overflow flag records the drop.
module fir_decim_out #(
  parameter int DATA_W = 10,
  parameter int DECIM  = 4,
  parameter int DEPTH  = 4
) (
  input  logic                       clk,
  input  logic                       rst_b,
  input  logic                       en,
  input  logic signed [DATA_W-1:0]   data_in,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic signed [DATA_W-1:0]   out_data,
  output logic [$clog2(DEPTH):0]     fill,
  output logic                       overflow,
  input  logic                       clr_ovf
);

  localparam int PH_W   = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam int PTR_W  = $clog2(DEPTH);
  localparam int FILL_W = PTR_W + 1;

  localparam logic [PH_W-1:0]   PH_LAST  = PH_W'(DECIM - 1);
  localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(DEPTH);

  // Registered state and its next-state values.
  logic [PH_W-1:0]   phase_q,    phase_d;
  logic [PTR_W-1:0]  wr_ptr_q,   wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q,   rd_ptr_d;
  logic [FILL_W-1:0] fill_q,     fill_d;
  logic              overflow_q, overflow_d;

  // FIFO storage.
  logic signed [DATA_W-1:0] mem_q [DEPTH];

  // Per-cycle decisions.
  logic keep;      // this en sample falls on phase 0
  logic full;      // FIFO holds DEPTH samples
  logic pop;       // head is transferred to the consumer
  logic push_ok;   // kept sample is written into the FIFO
  logic drop;      // kept sample is lost because the FIFO is full

  // Decide keep / pop / push / drop for this cycle.
  always_comb begin
    keep    = en && (phase_q == '0);
    full    = (fill_q == FILL_MAX);
    pop     = (fill_q != '0) && out_ready;
    // A pop in the same cycle frees a slot, so a full FIFO still accepts.
    push_ok = keep && (!full || pop);
    drop    = keep && full && !pop;
  end

  // Next-state logic for phase, pointers, occupancy and the sticky flag.
  always_comb begin
    phase_d    = phase_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    fill_d     = fill_q;
    overflow_d = overflow_q;

    // The phase follows en only; a drop does not disturb the cadence.
    if (en) begin
      phase_d = (phase_q == PH_LAST) ? '0 : phase_q + 1'b1;
    end

    // Pointers are PTR_W wide and DEPTH is a power of two, so they wrap
    // modulo DEPTH by themselves.
    if (push_ok) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end

    unique case ({push_ok, pop})
      2'b10:   fill_d = fill_q + 1'b1;
      2'b01:   fill_d = fill_q - 1'b1;
      default: fill_d = fill_q;
    endcase

    // A drop wins over a clear in the same cycle.
    if (drop) begin
      overflow_d = 1'b1;
    end else if (clr_ovf) begin
      overflow_d = 1'b0;
    end
  end

  // Control state register with synchronous active-low reset.
  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge values of its neighbours.
  always_ff @(posedge clk) begin
    if (!rst_b) begin
      phase_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fill_q     <= '0;
      overflow_q <= 1'b0;
    end else begin
      phase_q    <= phase_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      fill_q     <= fill_d;
      overflow_q <= overflow_d;
    end
  end

  // FIFO write port; entries are only ever read while they hold valid data.
  // NOTE: the storage array is deliberately not reset; fill_q and the
  // pointers define which entries are meaningful, and out_data is forced to
  // zero while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (rst_b && push_ok) begin
      mem_q[wr_ptr_q] <= data_in;
    end
  end

  // Outputs come from registered state only.
  always_comb begin
    out_valid = (fill_q != '0);
    out_data  = out_valid ? mem_q[rd_ptr_q] : '0;
    fill      = fill_q;
    overflow  = overflow_q;
  end

endmodule
